rx_axis_frame_checker: RTL and testbench

//   Receive-side sink for the IPG MAC+PHY loopback: consumes MAC RX AXI-stream beats (no backpressure), checks

---
 rtl/rx_axis_frame_checker.sv | 155 +++++++++++++++
 tb/tb_rx_axis_frame_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_axis_frame_checker.sv
// RX AXI-stream sink: checks framing, keep, tuser and an incrementing payload, and counts frames/bytes.
// Define RX_CHECKER_GAP_STATS_EN to build the inter-frame gap statistics (last_gap/min_gap).
module rx_axis_frame_checker #(
  parameter int DATA_WIDTH      = 64,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int RX_USER_WIDTH   = 1,
  parameter int MAX_FRAME_WORDS = 190,
  parameter int CNT_WIDTH       = 32,
  parameter int GAP_WIDTH       = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic [DATA_WIDTH-1:0]    rx_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    rx_axis_tkeep,
  input  logic                     rx_axis_tvalid,
  input  logic                     rx_axis_tlast,
  input  logic [RX_USER_WIDTH-1:0] rx_axis_tuser,
  input  logic                     check_enable,
  input  logic [DATA_WIDTH-1:0]    pattern_seed,
  output logic                     frame_done,
  output logic                     frame_bad,
  output logic                     err_pattern,
  output logic                     err_keep,
  output logic                     err_user,
  output logic                     err_oversize,
  output logic [15:0]              last_frame_len,
  output logic [CNT_WIDTH-1:0]     good_frame_count,
  output logic [CNT_WIDTH-1:0]     bad_frame_count,
  output logic [CNT_WIDTH-1:0]     byte_count,
  output logic [GAP_WIDTH-1:0]     last_gap,
  output logic [GAP_WIDTH-1:0]     min_gap,
  output logic                     busy
);
  localparam int KW = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [KW-1:0] KMAX = KW'(MAX_FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;
  state_t state;

  logic [KW-1:0] k;
  logic          chk_en_q;
  logic          pat_acc, keep_acc, user_acc, ovs_acc;
  logic [15:0]   len_acc;

  logic                  first, chk_cur, pat_hit, keep_bad, ovs_cur;
  logic                  pat_f, keep_f, user_f, ovs_f, bad_f;
  logic [KW-1:0]         k_cur;
  logic [DATA_WIDTH-1:0] exp_word;
  logic [16:0]           len_sum;
  logic [15:0]           len_f;

  // Beat 0 arrives in IDLE, so per-frame accumulators restart from zero there.
  always_comb begin
    first    = (state == IDLE);
    k_cur    = first ? '0 : k;
    chk_cur  = first ? check_enable : chk_en_q;
    exp_word = pattern_seed + DATA_WIDTH'(k_cur);
    pat_hit  = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++)
      if (rx_axis_tkeep[i] && rx_axis_tdata[8*i +: 8] != exp_word[8*i +: 8]) pat_hit = 1'b1;
    if (rx_axis_tlast)
      keep_bad = (rx_axis_tkeep == '0) ||
                 ((rx_axis_tkeep & (rx_axis_tkeep + KEEP_WIDTH'(1))) != '0);
    else
      keep_bad = (rx_axis_tkeep != '1);
    ovs_cur  = (k_cur == KMAX);
    pat_f    = (!first && pat_acc)  || (chk_cur && pat_hit);
    keep_f   = (!first && keep_acc) || keep_bad;
    user_f   = (!first && user_acc) || rx_axis_tuser[0];
    ovs_f    = (!first && ovs_acc)  || ovs_cur;
    bad_f    = pat_f || keep_f || user_f || ovs_f;
    len_sum  = {1'b0, (first ? 16'd0 : len_acc)} + 17'($countones(rx_axis_tkeep));
    len_f    = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state            <= IDLE;
      k                <= '0;
      chk_en_q         <= 1'b0;
      {pat_acc, keep_acc, user_acc, ovs_acc} <= '0;
      len_acc          <= '0;
      frame_done       <= 1'b0;
      frame_bad        <= 1'b0;
      err_pattern      <= 1'b0;
      err_keep         <= 1'b0;
      err_user         <= 1'b0;
      err_oversize     <= 1'b0;
      last_frame_len   <= '0;
      good_frame_count <= '0;
      bad_frame_count  <= '0;
      byte_count       <= '0;
    end else begin
      frame_done <= 1'b0;
      if (rx_axis_tvalid) begin
        pat_acc  <= pat_f;
        keep_acc <= keep_f;
        user_acc <= user_f;
        ovs_acc  <= ovs_f;
        len_acc  <= len_f;
        k        <= ovs_cur ? KMAX : k_cur + KW'(1);
        if (first) chk_en_q <= check_enable;
        if (rx_axis_tlast) begin
          state          <= IDLE;
          frame_done     <= 1'b1;
          frame_bad      <= bad_f;
          err_pattern    <= pat_f;
          err_keep       <= keep_f;
          err_user       <= user_f;
          err_oversize   <= ovs_f;
          last_frame_len <= len_f;
          if (bad_f) bad_frame_count <= bad_frame_count + CNT_WIDTH'(1);
          else begin
            good_frame_count <= good_frame_count + CNT_WIDTH'(1);
            byte_count       <= byte_count + CNT_WIDTH'(len_f);
          end
        end else begin
          state <= (ovs_cur || state == DROP) ? DROP : FRAME;
        end
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef RX_CHECKER_GAP_STATS_EN
  logic                 gap_valid;
  logic [GAP_WIDTH-1:0] gap_cnt;

  // gap_valid tracks the tlast beat so a back-to-back beat 0 already sees it set.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      gap_valid <= 1'b0;
      gap_cnt   <= '0;
      last_gap  <= '0;
      min_gap   <= '1;
    end else if (rx_axis_tvalid) begin
      if (first && gap_valid) begin
        last_gap <= gap_cnt;
        if (gap_cnt < min_gap) min_gap <= gap_cnt;
      end
      if (rx_axis_tlast) begin
        gap_valid <= 1'b1;
        gap_cnt   <= '0;
      end
    end else if (state == IDLE && gap_cnt != '1) begin
      gap_cnt <= gap_cnt + GAP_WIDTH'(1);
    end
  end
`else
  assign last_gap = '0;
  assign min_gap  = '0;
`endif

endmodule

// File: tb/tb_rx_axis_frame_checker.sv
// Randomized + directed bench for rx_axis_frame_checker against a frame-level reference model.
module tb_rx_axis_frame_checker;
  localparam int MAXW = 190;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [63:0] rx_axis_tdata = '0;
  logic [7:0]  rx_axis_tkeep = '0;
  logic        rx_axis_tvalid = 1'b0;
  logic        rx_axis_tlast = 1'b0;
  logic [0:0]  rx_axis_tuser = '0;
  logic        check_enable = 1'b0;
  logic [63:0] pattern_seed = '0;
  logic        frame_done, frame_bad, err_pattern, err_keep, err_user, err_oversize, busy;
  logic [15:0] last_frame_len, last_gap, min_gap;
  logic [31:0] good_frame_count, bad_frame_count, byte_count;

  rx_axis_frame_checker dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tlast(rx_axis_tlast), .rx_axis_tuser(rx_axis_tuser),
    .check_enable(check_enable), .pattern_seed(pattern_seed), .frame_done(frame_done),
    .frame_bad(frame_bad), .err_pattern(err_pattern), .err_keep(err_keep), .err_user(err_user),
    .err_oversize(err_oversize), .last_frame_len(last_frame_len), .good_frame_count(good_frame_count),
    .bad_frame_count(bad_frame_count), .byte_count(byte_count), .last_gap(last_gap),
    .min_gap(min_gap), .busy(busy));

  always #5 rx_clk = ~rx_clk;

`ifdef RX_CHECKER_GAP_STATS_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: collects a frame, judges it at tlast ----------------
  logic [63:0] q_data[$];
  logic [7:0]  q_keep[$];
  logic        q_user[$];
  logic [63:0] m_seed;
  bit          m_chk, in_frame, have_done;
  longint      cyc, last_tlast_cyc;
  bit          e_done, e_bad, e_pat, e_keep, e_user, e_ovs;
  int          e_len;
  logic [31:0] e_good, e_badc, e_bytes;
  longint      e_last_gap, e_min_gap;

  task automatic judge_frame();
    int n = q_data.size();
    longint len = 0;
    e_pat = 0; e_keep = 0; e_user = 0;
    e_ovs = (n > MAXW);
    for (int i = 0; i < n; i++) begin
      logic [63:0] ew = m_seed + 64'((i < MAXW) ? i : MAXW);
      bit legal = 0;
      for (int b = 0; b < 8; b++)
        if (m_chk && q_keep[i][b] && q_data[i][8*b +: 8] != ew[8*b +: 8]) e_pat = 1;
      if (i == n - 1) begin
        for (int j = 1; j <= 8; j++) if (int'(q_keep[i]) == (1 << j) - 1) legal = 1;
      end else legal = (q_keep[i] == 8'hFF);
      if (!legal) e_keep = 1;
      if (q_user[i]) e_user = 1;
      len += $countones(q_keep[i]);
    end
    e_len = (len > 65535) ? 65535 : int'(len);
    e_bad = e_pat | e_keep | e_user | e_ovs;
    if (e_bad) e_badc++;
    else begin e_good++; e_bytes += 32'(e_len); end
  endtask

  always @(posedge rx_clk) begin
    if (rx_rst) begin
      in_frame = 0; have_done = 0; e_done = 0; cyc = 0; last_tlast_cyc = 0;
      e_bad = 0; e_pat = 0; e_keep = 0; e_user = 0; e_ovs = 0; e_len = 0;
      e_good = 0; e_badc = 0; e_bytes = 0; e_last_gap = 0; e_min_gap = GAP_EN ? 65535 : 0;
      q_data.delete(); q_keep.delete(); q_user.delete();
    end else begin
      cyc++;
      e_done = 0;
      if (rx_axis_tvalid) begin
        if (!in_frame) begin
          m_seed = pattern_seed; m_chk = check_enable;
          q_data.delete(); q_keep.delete(); q_user.delete();
          if (have_done && GAP_EN) begin
            longint g = cyc - last_tlast_cyc - 1;
            if (g > 65535) g = 65535;
            e_last_gap = g;
            if (g < e_min_gap) e_min_gap = g;
          end
          in_frame = 1;
        end
        q_data.push_back(rx_axis_tdata);
        q_keep.push_back(rx_axis_tkeep);
        q_user.push_back(rx_axis_tuser[0]);
        if (rx_axis_tlast) begin
          judge_frame();
          e_done = 1; in_frame = 0; have_done = 1; last_tlast_cyc = cyc;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge rx_clk) begin
    if (!rx_rst) begin
      chk("frame_done", frame_done, e_done);
      chk("busy", busy, in_frame);
      chk("good_frame_count", good_frame_count, e_good);
      chk("bad_frame_count", bad_frame_count, e_badc);
      chk("byte_count", byte_count, e_bytes);
      chk("last_gap", last_gap, 64'(e_last_gap));
      chk("min_gap", min_gap, 64'(e_min_gap));
      if (e_done) begin
        chk("frame_bad", frame_bad, e_bad);
        chk("err_pattern", err_pattern, e_pat);
        chk("err_keep", err_keep, e_keep);
        chk("err_user", err_user, e_user);
        chk("err_oversize", err_oversize, e_ovs);
        chk("last_frame_len", last_frame_len, 64'(e_len));
      end
    end
  end

  int done_cnt = 0;
  always @(posedge rx_clk) if (frame_done) done_cnt++;

  // ---------------- stimulus ----------------
  task automatic beat(input logic [63:0] d, input logic [7:0] k, input bit l, input bit u);
    rx_axis_tvalid = 1; rx_axis_tdata = d; rx_axis_tkeep = k; rx_axis_tlast = l; rx_axis_tuser = u;
    @(negedge rx_clk);
    rx_axis_tvalid = 0; rx_axis_tlast = 0; rx_axis_tuser = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  task automatic frame(input int n, input logic [63:0] seed, input bit ce, input int corrupt,
                       input logic [7:0] lastkeep, input int user_beat, input int badkeep_beat);
    pattern_seed = seed; check_enable = ce;
    for (int i = 0; i < n; i++) begin
      logic [63:0] d = seed + 64'(i);
      logic [7:0]  k = (i == n - 1) ? lastkeep : ((i == badkeep_beat) ? 8'h7F : 8'hFF);
      if (i == corrupt) d = d ^ 64'h1;
      beat(d, k, i == n - 1, i == user_beat);
      if (i == 0) check_enable = 1'($urandom);
    end
  endtask

  initial begin
    int rec;
    repeat (3) @(negedge rx_clk);
    rx_rst = 0;
    chk("rst_good", good_frame_count, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_min_gap", min_gap, GAP_EN ? 64'hFFFF : 64'h0);

    frame(8, 64'd1, 1, -1, 8'hFF, -1, -1);
    chk("t1_done", frame_done, 1);
    chk("t1_bad", frame_bad, 0);
    chk("t1_len", last_frame_len, 64);
    chk("t1_good", good_frame_count, 1);
    chk("t1_bytes", byte_count, 64);
    idle(2);

    frame(8, 64'd1, 1, 3, 8'hFF, -1, -1);   // beat 4 carries 5 instead of 4
    chk("t2_pat", err_pattern, 1);
    chk("t2_badcnt", bad_frame_count, 1);
    chk("t2_bytes", byte_count, 64);
    idle(1);
    frame(8, 64'd1, 0, 3, 8'hFF, -1, -1);
    chk("t2_nochk_good", good_frame_count, 2);
    idle(1);

    frame(1, 64'd1, 1, -1, 8'h0F, -1, -1);
    chk("t3_len", last_frame_len, 4);
    chk("t3_good", good_frame_count, 3);
    idle(1);
    frame(3, 64'd9, 1, -1, 8'h0D, -1, -1);
    chk("t3_keep_last", err_keep, 1);
    idle(1);
    frame(3, 64'd9, 1, -1, 8'hFF, -1, 1);
    chk("t3_keep_mid", err_keep, 1);
    idle(1);

    rec = done_cnt;
    frame(200, 64'd100, 0, -1, 8'hFF, -1, -1);
    chk("t4_ovs", err_oversize, 1);
    chk("t4_len", last_frame_len, 1600);
    idle(2);
    chk("t4_single_done", done_cnt - rec, 1);
    chk("t4_busy", busy, 0);

    // reset mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) beat(64'd7 + 64'(i), 8'hFF, 0, 0);
    rx_rst = 1; idle(2); rx_rst = 0;
    rec = done_cnt;
    frame(8, 64'd7, 1, -1, 8'hFF, -1, -1);
    chk("t6_first_gap", last_gap, 0);
    idle(2);
    chk("t6_one_done", done_cnt - rec, 1);
    chk("t6_good", good_frame_count, 1);

    // gaps: 3 idle cycles (2 already elapsed + 1), then back-to-back
    idle(1);
    frame(2, 64'd3, 1, -1, 8'hFF, -1, -1);
    chk("t5_gap3", last_gap, GAP_EN ? 3 : 0);
    frame(2, 64'd5, 1, -1, 8'hFF, -1, -1);
    chk("t5_gap0", last_gap, 0);
    chk("t5_min", min_gap, 0);
    idle(2);

    for (int f = 0; f < 60; f++) begin
      int n = ($urandom % 8 == 0) ? 189 + int'($urandom % 6) : 1 + int'($urandom % 12);
      int corrupt = ($urandom % 4 == 0) ? int'($urandom % n) : -1;
      int ub = ($urandom % 6 == 0) ? int'($urandom % n) : -1;
      int kb = ($urandom % 6 == 0 && n > 1) ? int'($urandom % (n - 1)) : -1;
      logic [7:0] lk = ($urandom % 4 == 0) ? 8'($urandom) : (8'hFF >> ($urandom % 8));
      frame(n, {$urandom, $urandom}, 1'($urandom), corrupt, lk, ub, kb);
      idle($urandom % 4);
    end
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
